gc_ramp_ctrl: RTL
=================

Name: gc_ramp_ctrl

Overview:
- Sequencer around the 8-bit loadable up/down counter with Gray-coded output. The block owns one counter instance and ramps it from a start value to a target value, one LSB per programmable step interval.
- Sits between control logic (volume/gain ramps, pointer sweeps) and consumers of the binary and Gray-coded count.
- The counter has no enable, so "hold" means reloading the counter with its own current value.

Parameters:
- DIV_W, 16, width of the step-interval divider.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  cancel an active ramp
- start_val  in  8  initial counter value, captured on accepted start
- target  in  8  final counter value, captured on accepted start
- step_div  in  DIV_W  clk cycles per step, captured on accepted start; 0 treated as 1
- value  out  8  binary counter value
- value_gc  out  8  Gray code of value: value ^ (value >> 1)
- dir  out  1  1 = counting up, 0 = counting down; valid while busy
- busy  out  1  high in LOAD and RAMP
- done  out  1  one-cycle pulse on ramp completion

Behaviour:
- Reset values:
  - value = 0x00, value_gc = 0x00.
  - dir = 0, busy = 0, done = 0.
  - State = IDLE, prescaler = 0, captured registers = 0.
- Counter control:
  - Every cycle the controller drives exactly one of: load(num), increment, decrement.
  - Hold = load with the current value.
  - value_gc is combinational from value, with no added latency.
- IDLE:
  - Counter holds.
  - start = 1 and abort = 0: capture start_val, target and step_div; go to LOAD.
  - start together with abort in IDLE: start is ignored.
- LOAD (1 cycle):
  - Counter loads start_val; value = start_val on the next edge.
  - dir = (target > start_val).
  - Prescaler cleared.
  - Next state is DONE if start_val == target, else RAMP.
- RAMP:
  - Prescaler counts 0..max(step_div,1)-1. Counter holds except on the tick cycle, when it steps ±1 per dir.
  - First step lands max(step_div,1) cycles after entering RAMP.
  - The step that makes value == target moves the FSM to DONE.
  - Total start-to-done latency = 2 + |target - start_val| * max(step_div,1) cycles (non-wrap case).
- DONE (1 cycle):
  - done = 1, busy = 0, counter holds.
  - Next state is IDLE. A start in this cycle is ignored.
- abort:
  - In LOAD or RAMP: counter holds its current value, next state is IDLE, no done pulse.
  - In LOAD, the load still completes that cycle.
  - abort in IDLE or DONE has no effect.
- start while busy: ignored; captured values are unchanged.
- Boundaries:
  - Without the optional feature, value never wraps: 0x00 is never decremented and 0xFF never incremented, because dir always points toward target.
  - step_div = 1: one step per cycle.
  - step_div = 0: identical to step_div = 1.
- Reset mid-ramp: immediate return to reset values; the ramp is not resumed.

Optional Feature:
- Macro: GC_RAMP_WRAP_EN.
- Defined:
  - Shortest modular path is used. With d = (target - start_val) mod 256, dir = 1 if d <= 128, else dir = 0.
  - d == 128 ties go up.
  - The counter wraps 0xFF->0x00 (up) or 0x00->0xFF (down).
  - Latency uses min(d, 256 - d) steps.
- Undefined:
  - Linear direction only, as described in Behaviour.
  - The wrap logic is absent.

Test Plan:
- Reset, then idle 10 cycles -> value = 0x00, value_gc = 0x00, busy = 0, done = 0; value stable (hold via self-load).
- start, start_val = 0x10, target = 0x14, step_div = 3:
  - value = 0x10 after LOAD; steps 0x11..0x14 every 3 cycles; value_gc = 0x18, 0x19, 0x1B, 0x1A, 0x1E.
  - done pulses 1 cycle at start+2+12; dir = 1.
- start, start_val = 0x05, target = 0x02, step_div = 0 -> one step per cycle 0x04, 0x03, 0x02; dir = 0; done at start+2+3.
- start, start_val = target = 0x7F -> value = 0x7F; done 2 cycles after start; no steps.
- Ramp 0x00->0xFF with step_div = 2:
  - abort when value = 0x20 -> value frozen at 0x20, busy falls next cycle, no done.
  - A start issued mid-ramp before the abort is ignored.
- GC_RAMP_WRAP_EN defined, start_val = 0xFE, target = 0x02, step_div = 1 -> sequence 0xFF, 0x00, 0x01, 0x02; dir = 1; done after 4 steps. Without the macro, the same stimulus gives dir = 0 and 252 down-steps.

Source files
------------

// File: rtl/gc_ramp_ctrl.sv
// Ramp sequencer driving an 8-bit load/inc/dec counter with Gray-coded output.
// Optional shortest-path wrap-around ramping is enabled by defining GC_RAMP_WRAP_EN.
module gc_ramp_ctrl #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       start_val,
  input  logic [7:0]       target,
  input  logic [DIV_W-1:0] step_div,
  output logic [7:0]       value,
  output logic [7:0]       value_gc,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StRamp, StDone} state_e;
  typedef enum logic [1:0] {CntLoad, CntInc, CntDec} cnt_op_e;

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  state_e           state_q, state_d;
  cnt_op_e          cnt_op;
  logic [7:0]       cnt_q, cnt_d, cnt_ld;
  logic [7:0]       sv_q, tgt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_q, presc_d, presc_last;
  logic             dir_q;
  logic             cap_en;
  logic             start_dir;
  logic             tick;
  logic [7:0]       step_val;

`ifdef GC_RAMP_WRAP_EN
  logic [7:0] fwd_dist;
  // Forward modular distance; exactly half-way (128) resolves upward.
  assign fwd_dist  = target - start_val;
  assign start_dir = (fwd_dist <= 8'd128);
`else
  assign start_dir = (target > start_val);
`endif

  // A divider of zero behaves like one: the tick fires every cycle.
  assign presc_last = (div_q == '0) ? '0 : div_q - DivOne;
  assign tick       = (presc_q == presc_last);
  assign step_val   = dir_q ? cnt_q + 8'd1 : cnt_q - 8'd1;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_op  = CntLoad;
    cnt_ld  = cnt_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cap_en  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // The load completes even when aborted.
        cnt_ld  = sv_q;
        presc_d = '0;
        if (abort)               state_d = StIdle;
        else if (sv_q == tgt_q)  state_d = StDone;
        else                     state_d = StRamp;
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tick) begin
          presc_d = '0;
          cnt_op  = dir_q ? CntInc : CntDec;
          if (step_val == tgt_q) state_d = StDone;
        end else begin
          presc_d = presc_q + DivOne;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter: exactly one of load/increment/decrement every cycle; hold is a self-load.
  always_comb begin
    case (cnt_op)
      CntInc:  cnt_d = cnt_q + 8'd1;
      CntDec:  cnt_d = cnt_q - 8'd1;
      default: cnt_d = cnt_ld;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      presc_q <= '0;
      cnt_q   <= 8'h00;
      sv_q    <= 8'h00;
      tgt_q   <= 8'h00;
      div_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      if (cap_en) begin
        sv_q  <= start_val;
        tgt_q <= target;
        div_q <= step_div;
        dir_q <= start_dir;
      end
    end
  end

  assign value    = cnt_q;
  assign value_gc = cnt_q ^ (cnt_q >> 1);
  assign dir      = dir_q;
  assign busy     = (state_q == StLoad) || (state_q == StRamp);
  assign done     = (state_q == StDone);

endmodule
